// File: rtl/fpga_ccff_loader.sv
// Wishbone-fed configuration chain loader: serialises 32-bit words MSB-first onto
// ccff_head_o under a divided prog_clk_o and captures ccff_tail_i for readback.
module fpga_ccff_loader #(
   parameter int DIV        = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        prog_clk_o,
   output logic        prog_reset_o,
   output logic        ccff_head_o,
   input  logic        ccff_tail_i
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = AW + 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);

   typedef enum logic [1:0] {IDLE, LOAD, LOW, HIGH} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [4:0]    idx_q, idx_d;
   logic [31:0]   sh_q, sh_d;
   logic [31:0]   rx_q, rx_d;
   logic [31:0]   tail_q, tail_d;
   logic [31:0]   bitcnt_q, bitcnt_d;
   logic          head_q, head_d;
   logic          pclk_q, pclk_d;
   logic [31:0]   fifo_q [FIFO_DEPTH];
   logic [31:0]   fifo_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          run_q, run_d, prst_q, prst_d, ovf_q, ovf_d;
   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;

   logic req, wr_data, wr_ctrl, full, empty, push, pop;
   logic unused_bits;

   assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[31:4], wbs_adr_i[1:0]};

   // Bus decode, control register, FIFO bookkeeping
   always_comb begin
      req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
      wr_data = req & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
      wr_ctrl = req & wbs_we_i & (wbs_adr_i[3:2] == 2'd1) & wbs_sel_i[0];
      full    = (level_q == LVL_FULL);
      empty   = (level_q == '0);
      ack_d   = req;
      run_d   = wr_ctrl ? wbs_dat_i[1] : run_q;
      prst_d  = wr_ctrl ? wbs_dat_i[0] : prst_q;
      pop     = (state_q == LOAD) & ~prst_d;
      push    = wr_data & ~prst_d & (~full | pop);
      ovf_d   = ovf_q;
      if (wr_ctrl & wbs_dat_i[2]) begin
         ovf_d = 1'b0;
      end else if (wr_data & ~prst_d & full & ~pop) begin
         ovf_d = 1'b1;
      end

      dat_d = '0;
      if (req & ~wbs_we_i) begin
         case (wbs_adr_i[3:2])
            2'd0:    dat_d = tail_q;
            2'd1:    dat_d = {30'd0, run_q, prst_q};
            2'd2:    dat_d = {23'd0, 5'(level_q), ovf_q, empty, full, (state_q != IDLE)};
            default: dat_d = bitcnt_q;
         endcase
      end

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         fifo_d[wr_ptr_q] = wbs_dat_i;
         wr_ptr_d         = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push & ~pop) begin
         level_d = level_q + LVL_ONE;
      end else if (pop & ~push) begin
         level_d = level_q - LVL_ONE;
      end
      if (prst_d) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   // Serialiser FSM
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      idx_d    = idx_q;
      sh_d     = sh_q;
      rx_d     = rx_q;
      tail_d   = tail_q;
      bitcnt_d = bitcnt_q;
      head_d   = head_q;
      case (state_q)
         IDLE: begin
            if (run_q & ~prst_q & ~empty) state_d = LOAD;
         end
         LOAD: begin
            sh_d    = fifo_q[rd_ptr_q];
            head_d  = sh_d[31];
            idx_d   = 5'd31;
            div_d   = '0;
            state_d = LOW;
         end
         LOW: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = HIGH;
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
         default: begin
            // Fabric has just sampled head on the rising edge; capture the returning bit once
            if (div_q == '0) begin
               rx_d     = {rx_q[30:0], ccff_tail_i};
               bitcnt_d = bitcnt_q + 32'd1;
            end
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (idx_q != 5'd0) begin
                  sh_d    = {sh_q[30:0], 1'b0};
                  head_d  = sh_q[30];
                  idx_d   = idx_q - 5'd1;
                  state_d = LOW;
               end else begin
                  tail_d  = rx_d;
                  state_d = (run_q & ~empty) ? LOAD : IDLE;
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end
      endcase
      if (prst_d) begin
         state_d  = IDLE;
         div_d    = '0;
         idx_d    = '0;
         rx_d     = '0;
         bitcnt_d = '0;
         head_d   = 1'b0;
      end
      pclk_d = (state_d == HIGH);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         div_q    <= '0;
         idx_q    <= '0;
         rx_q     <= '0;
         tail_q   <= '0;
         bitcnt_q <= '0;
         head_q   <= 1'b0;
         pclk_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         run_q    <= 1'b0;
         prst_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         idx_q    <= idx_d;
         rx_q     <= rx_d;
         tail_q   <= tail_d;
         bitcnt_q <= bitcnt_d;
         head_q   <= head_d;
         pclk_q   <= pclk_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         run_q    <= run_d;
         prst_q   <= prst_d;
         ovf_q    <= ovf_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      sh_q   <= sh_d;
      fifo_q <= fifo_d;
   end

   assign wbs_ack_o    = ack_q;
   assign wbs_dat_o    = dat_q;
   assign prog_clk_o   = pclk_q;
   assign prog_reset_o = prst_q;
   assign ccff_head_o  = head_q;
endmodule

// File: tb/tb_fpga_ccff_loader.sv
// Directed bench for fpga_ccff_loader with a 32-stage bench model of the fabric chain.
module tb_fpga_ccff_loader;
   localparam int TCLK = 10;
   localparam logic [1:0] A_DATA = 2'd0, A_CTRL = 2'd1, A_STAT = 2'd2, A_BCNT = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_i, dat_o;
   logic        ack, prog_clk, prog_reset, head;
   logic        tail  = 1'b0;
   logic [31:0] chain = '0;
   logic [31:0] cap   = '0;
   int          rises = 0;
   time         rise_t [0:511];
   time         last_fall = 0;
   time         t_acc, t_run;
   logic        snap_pclk, snap_prst;
   int          checks = 0;
   int          failures = 0;
   int          base, n, held;

   always #(TCLK/2) clk = ~clk;

   fpga_ccff_loader #(.DIV(2), .FIFO_DEPTH(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .prog_clk_o(prog_clk), .prog_reset_o(prog_reset),
      .ccff_head_o(head), .ccff_tail_i(tail)
   );

   // Chain model: tail seen at a rising edge is the head bit from 32 edges earlier
   always @(posedge prog_clk) begin
      tail  <= chain[31];
      chain <= {chain[30:0], head};
      cap   <= {cap[30:0], head};
      rise_t[rises[8:0]] <= $time;
      rises <= rises + 1;
   end

   always @(negedge prog_clk) last_fall <= $time;

   initial begin
      #(TCLK * 50000);
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdata);
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = {28'd0, a, 2'b00}; dat_i = d;
      @(posedge clk);
      t_acc = $time;
      #1;
      snap_pclk = prog_clk;
      snap_prst = prog_reset;
      rdata     = dat_o;
      check("ack_pulse", {31'd0, ack}, 32'd1);
      @(negedge clk);
      stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
      @(posedge clk);
      #1;
      check("ack_single", {31'd0, ack}, 32'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      wb_xfer(1'b1, a, d, 4'hF, dummy);
   endtask

   task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] v;
      wb_xfer(1'b0, a, 32'd0, 4'hF, v);
      check(tag, v, exp);
   endtask

   initial begin
      logic [31:0] dummy;
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {28'd0, ack, prog_clk, prog_reset, head}, 32'd0);
      check("reset_dat_o", dat_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      rd_check("reset_status", A_STAT, 32'h004);
      rd_check("reset_bitcnt", A_BCNT, 32'd0);
      rd_check("reset_tailword", A_DATA, 32'd0);
      wb_xfer(1'b1, A_CTRL, 32'h1, 4'hE, dummy);
      check("ctrl_sel0_ignored", {31'd0, prog_reset}, 32'd0);
      rd_check("ctrl_read_idle", A_CTRL, 32'd0);

      // Single word
      wr(A_DATA, 32'hA500_0001);
      base = rises;
      wr(A_CTRL, 32'h2);
      t_run = t_acc;
      repeat (150) @(posedge clk);
      #1;
      check("single_rises", rises - base, 32'd32);
      check("single_head_bits", cap, 32'hA500_0001);
      check("single_first_rise", 32'(rise_t[base] - t_run), 32'(4 * TCLK));
      check("single_last_fall", 32'(last_fall - t_run), 32'(130 * TCLK));
      rd_check("single_bitcnt", A_BCNT, 32'd32);
      rd_check("single_status_idle", A_STAT, 32'h004);

      // Loopback readback, back-to-back words
      base = rises;
      wr(A_DATA, 32'h1234_5678);
      wr(A_DATA, 32'hDEAD_BEEF);
      repeat (300) @(posedge clk);
      #1;
      check("loop_rises", rises - base, 32'd64);
      check("loop_bit_period", 32'(rise_t[base + 31] - rise_t[base + 30]), 32'(4 * TCLK));
      check("loop_word_gap", 32'(rise_t[base + 32] - rise_t[base + 31]), 32'(5 * TCLK));
      rd_check("loop_tailword", A_DATA, 32'h1234_5678);
      rd_check("loop_bitcnt", A_BCNT, 32'd96);

      // Overflow
      wr(A_CTRL, 32'h0);
      wr(A_DATA, 32'h1111_1111);
      wr(A_DATA, 32'h2222_2222);
      wr(A_DATA, 32'h3333_3333);
      wr(A_DATA, 32'h4444_4444);
      wr(A_DATA, 32'h5555_5555);
      rd_check("ovf_status", A_STAT, 32'h04A);
      wr(A_CTRL, 32'h4);
      rd_check("ovf_cleared_status", A_STAT, 32'h042);
      rd_check("ovf_clr_reads_zero", A_CTRL, 32'd0);
      base = rises;
      wr(A_CTRL, 32'h2);
      repeat (600) @(posedge clk);
      #1;
      check("ovf_shift_rises", rises - base, 32'd128);
      rd_check("ovf_drain_status", A_STAT, 32'h004);
      rd_check("ovf_tailword", A_DATA, 32'h3333_3333);
      rd_check("ovf_bitcnt", A_BCNT, 32'd224);

      // Abort mid-word
      base = rises;
      wr(A_DATA, 32'hCAFE_F00D);
      n = 0;
      while (((rises - base) < 10) && (n < 200)) begin
         @(posedge clk);
         n++;
      end
      check("abort_reached_bit10", {31'd0, ((rises - base) >= 10)}, 32'd1);
      wr(A_CTRL, 32'h3);
      check("abort_prog_clk", {31'd0, snap_pclk}, 32'd0);
      check("abort_prog_reset", {31'd0, snap_prst}, 32'd1);
      held = rises;
      rd_check("abort_status", A_STAT, 32'h004);
      rd_check("abort_bitcnt", A_BCNT, 32'd0);
      rd_check("abort_tailword", A_DATA, 32'h3333_3333);
      wr(A_DATA, 32'h0000_0001);
      rd_check("abort_push_dropped", A_STAT, 32'h004);
      repeat (20) @(posedge clk);
      check("abort_clock_quiet", rises - held, 32'd0);

      // RUN cleared mid-word
      wr(A_CTRL, 32'h0);
      wr(A_DATA, 32'h0123_4567);
      wr(A_DATA, 32'h89AB_CDEF);
      base = rises;
      wr(A_CTRL, 32'h2);
      n = 0;
      while (((rises - base) < 5) && (n < 200)) begin
         @(posedge clk);
         n++;
      end
      check("runclr_started", {31'd0, ((rises - base) >= 5)}, 32'd1);
      wr(A_CTRL, 32'h0);
      repeat (200) @(posedge clk);
      #1;
      check("runclr_rises", rises - base, 32'd32);
      check("runclr_head_bits", cap, 32'h0123_4567);
      rd_check("runclr_bitcnt", A_BCNT, 32'd32);
      rd_check("runclr_status", A_STAT, 32'h010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fpga_ccff_loader.md
# fpga_ccff_loader

Wishbone-slave configuration loader that sits directly upstream of the FPGA fabric's configuration chain. Firmware pushes 32-bit bitstream words over Wishbone; the block serialises them MSB-first onto `ccff_head_o`, generates a divided `prog_clk_o`, and drives `prog_reset_o`. It also captures the bits returning on `ccff_tail_i` for readback verification. It replaces the GPIO-driven `prog_clk`/`ccff_head` path when the chain is programmed from the SoC.

## Interface
- `DIV`, default 2: `wb_clk_i` cycles per `prog_clk_o` half-period; legal range 1..255.
- `FIFO_DEPTH`, default 4: input word FIFO depth; power of two, 2..16.
- `wb_clk_i`  in  1  the single clock for the block.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `wbs_stb_i`  in  1  strobe, already qualified by the upstream address decode.
- `wbs_cyc_i`  in  1  bus cycle.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte selects; only `sel[0]` is used, and only for CTRL.
- `wbs_adr_i`  in  32  address; only `[3:2]` is decoded.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data.
- `prog_clk_o`  out  1  configuration clock to the fabric.
- `prog_reset_o`  out  1  configuration reset to the fabric; equals CTRL[0].
- `ccff_head_o`  out  1  serial configuration data to the fabric.
- `ccff_tail_i`  in  1  serial data returning from the end of the chain.

## Operation
- Register map, selected by `adr[3:2]`:
  - **0 DATA**
    - Write pushes `wbs_dat_i` into the FIFO; `sel` is ignored.
    - A write while the FIFO is full is dropped and sets sticky OVF.
    - Read returns TAILWORD, the last complete 32-bit word captured from `ccff_tail_i`.
  - **1 CTRL (RW)**
    - Writes occur only when `sel[0]` is set.
    - bit0 PRST drives `prog_reset_o`.
    - bit1 RUN.
    - bit2 OVF_CLR is write-1-to-clear for OVF and self-clears; it always reads 0.
  - **2 STATUS (RO)**
    - bit0 BUSY: state ≠ IDLE.
    - bit1 FULL.
    - bit2 EMPTY.
    - bit3 OVF.
    - [8:4] LEVEL.
  - **3 BITCNT (RO)**: 32-bit count of completed `prog_clk_o` rising edges; wraps modulo 2^32.
- FSM states are IDLE, LOAD, LOW and HIGH.
  - **IDLE**
    - `prog_clk_o` = 0.
    - Moves to LOAD when RUN=1, PRST=0 and the FIFO is non-empty.
  - **LOAD** (1 cycle)
    - Pops the FIFO head into the 32-bit shift register.
    - Sets `ccff_head_o` = word[31] and the bit index to 31.
    - Moves to LOW.
  - **LOW**
    - `prog_clk_o` = 0 for DIV cycles, then moves to HIGH.
  - **HIGH**
    - `prog_clk_o` = 1 for DIV cycles.
    - In the first HIGH cycle the block shifts `ccff_tail_i` into the RX register LSB-first and increments BITCNT.
    - At the end of HIGH with index > 0: shift, `ccff_head_o` = next bit, decrement the index, go to LOW.
    - At the end of HIGH with index = 0: copy RX to TAILWORD, then go to LOAD if RUN=1 and the FIFO is non-empty, otherwise to IDLE.
- Clearing RUN mid-word does not abort; the current word completes, then the FSM goes to IDLE.
- PRST=1 overrides the FSM on the cycle after the CTRL write:
  - FSM → IDLE, `prog_clk_o` = 0.
  - FIFO flushed; BITCNT, RX and the bit index cleared.
  - TAILWORD is kept.
  - FIFO pushes are dropped without setting OVF.
- If a DATA push and an FSM pop happen in the same cycle, both take effect; LEVEL is unchanged. A push into a full FIFO in the same cycle as a pop is accepted.
- Reset values (`wb_rst_i`):
  - FSM IDLE; FIFO empty.
  - `prog_clk_o` = 0, `ccff_head_o` = 0, `prog_reset_o` = 0.
  - RUN = 0, OVF = 0.
  - BITCNT, RX and TAILWORD = 0.
  - `wbs_ack_o` = 0, `wbs_dat_o` = 0.

## Timing
- Ack
  - `wbs_ack_o` is registered and asserts one cycle after `stb & cyc & ~ack`.
  - Each access gets exactly one single-cycle pulse; back-to-back accesses ack every other cycle.
  - `wbs_dat_o` is valid in the same cycle as ack.
- Write side effects (FIFO push, CTRL update) occur on the ack cycle edge.
- Data/clock alignment: `ccff_head_o` changes only while `prog_clk_o` = 0, at least DIV cycles before the rising edge. The fabric samples on the rising edge.
- Per-bit period is 2·DIV cycles.
  - The first word costs 1 (IDLE→LOAD) + 1 (LOAD) + 64·DIV cycles.
  - Back-to-back words add exactly 1 LOAD cycle (clock held low) between words.
- STATUS reads reflect state as of the cycle the request was sampled.

## Test plan
- **Reset state:** assert `wb_rst_i` for 2 cycles → all outputs 0; STATUS reads 0x004 (EMPTY); BITCNT reads 0.
- **Single word:**
  - Stimulus: DIV=2, write DATA=0xA5000001, CTRL=0x2.
  - Required response:
    - The `ccff_head_o` sequence sampled at 32 `prog_clk_o` rising edges equals the bits of 0xA5000001, MSB first.
    - BITCNT=32; BUSY returns to 0 after 1+1+128 cycles.
- **Loopback readback:**
  - Stimulus: `ccff_tail_i` tied to `ccff_head_o` delayed by 32 `prog_clk_o` edges (bench model of the chain); push 0x12345678, then 0xDEADBEEF.
  - Required response: after the second word, the DATA read returns 0x12345678; exactly one extra low cycle appears between words.
- **Overflow:**
  - Stimulus: RUN=0, FIFO_DEPTH=4, push 5 words.
  - Required response: STATUS FULL=1, OVF=1, LEVEL=4; writing CTRL=0x4 clears OVF; setting RUN then shifts exactly 128 bits.
- **Abort:**
  - Stimulus: write CTRL=0x3 mid-word (bit 10).
  - Required response: next cycle `prog_clk_o`=0, `prog_reset_o`=1, FIFO empty, BITCNT=0; TAILWORD unchanged.
- **RUN cleared mid-word:**
  - Stimulus: RUN=1 with 2 words queued; clear RUN during word 1.
  - Required response: word 1 completes (BITCNT=32); FSM idles with LEVEL=1.
